// File: rtl/obi_pkg.sv
// obi_pkg: OBI request/response bundles shared by bus masters, slaves and the watchdog.
package obi_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

// File: rtl/obi_wdog_pkg.sv
// obi_wdog_pkg: watchdog FSM state encoding and default error read data.
package obi_wdog_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        ERR_RESP,
        FLUSH
    } wdog_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;
endpackage

// File: rtl/obi_periph_watchdog.sv
// obi_periph_watchdog: single-outstanding OBI stall watchdog that answers hung peripheral transactions with ERR_RDATA.
// Optional saturating timeout counter on err_count_o is enabled by defining OBI_WDOG_ERR_COUNT_EN.
module obi_periph_watchdog
    import obi_pkg::*;
    import obi_wdog_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    slave_req_i,
    output obi_resp_t   slave_resp_o,
    output obi_req_t    periph_req_o,
    input  obi_resp_t   periph_resp_i,
    output logic        timeout_intr_o,
    output logic [31:0] err_addr_o,
    output logic [15:0] err_count_o
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    wdog_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   addr_q, err_addr_q;
    logic          flush_q, intr_q;
    logic          fwd, last, to_gnt, pass_rv, counting;

    assign fwd      = state_q == IDLE || state_q == WAIT_GNT;
    assign last     = cnt_q == LAST;
    assign to_gnt   = state_q == WAIT_GNT && !periph_resp_i.gnt && last;
    assign pass_rv  = state_q == WAIT_RVALID && periph_resp_i.rvalid;
    assign counting = state_q == WAIT_GNT || state_q == WAIT_RVALID || state_q == FLUSH;

    always_comb begin
        periph_req_o        = slave_req_i;
        periph_req_o.req    = slave_req_i.req && fwd && !to_gnt;
        slave_resp_o.gnt    = (fwd && periph_resp_i.gnt) || to_gnt;
        slave_resp_o.rvalid = pass_rv || state_q == ERR_RESP;
        slave_resp_o.rdata  = pass_rv ? periph_resp_i.rdata : (state_q == ERR_RESP ? ERR_RDATA : '0);
    end

    // Peripheral gnt/rvalid is tested before the timeout so it wins a same-cycle tie.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (slave_req_i.req) state_d = periph_resp_i.gnt ? WAIT_RVALID : WAIT_GNT;
            WAIT_GNT:    state_d = periph_resp_i.gnt ? WAIT_RVALID : (last ? ERR_RESP : WAIT_GNT);
            WAIT_RVALID: state_d = periph_resp_i.rvalid ? IDLE : (last ? ERR_RESP : WAIT_RVALID);
            ERR_RESP:    state_d = flush_q ? FLUSH : IDLE;
            FLUSH:       state_d = (periph_resp_i.rvalid || last) ? IDLE : FLUSH;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            err_addr_q <= '0;
            flush_q    <= 1'b0;
            intr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : (counting ? cnt_q + CW'(1) : cnt_q);
            if (state_q == IDLE && slave_req_i.req) addr_q <= slave_req_i.addr;
            if (state_d == ERR_RESP) flush_q <= state_q == WAIT_RVALID;
            intr_q <= state_d == ERR_RESP;
            if (state_q == ERR_RESP) err_addr_q <= addr_q;
        end
    end

    assign timeout_intr_o = intr_q;
    assign err_addr_o     = err_addr_q;

`ifdef OBI_WDOG_ERR_COUNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_cnt_q <= '0;
        else if (state_q == ERR_RESP && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign err_count_o = err_cnt_q;
`else
    assign err_count_o = '0;
`endif
endmodule

// File: tb/tb_obi_periph_watchdog.sv
// tb_obi_periph_watchdog: directed-vector bench for obi_periph_watchdog with TIMEOUT_CYCLES=8.
module tb_obi_periph_watchdog;
    import obi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    obi_req_t    sreq, preq;
    obi_resp_t   sresp, presp;
    logic        intr;
    logic [31:0] eaddr;
    logic [15:0] ecnt;
    int          checks = 0;
    int          failures = 0;

`ifdef OBI_WDOG_ERR_COUNT_EN
    localparam int EN = 1;
`else
    localparam int EN = 0;
`endif

    always #5 clk = ~clk;

    obi_periph_watchdog #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .slave_req_i(sreq),
        .slave_resp_o(sresp),
        .periph_req_o(preq),
        .periph_resp_i(presp),
        .timeout_intr_o(intr),
        .err_addr_o(eaddr),
        .err_count_o(ecnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic [31:0] a, input logic we, input logic g,
                       input logic rv, input logic [31:0] rd);
        sreq.req    = r;
        sreq.addr   = a;
        sreq.we     = we;
        sreq.be     = 4'hF;
        sreq.wdata  = a ^ 32'h5A5A_5A5A;
        presp.gnt   = g;
        presp.rvalid = rv;
        presp.rdata = rd;
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0);
        repeat (3) nxt;
        chk("rst_rvalid", {31'd0, sresp.rvalid}, 0);
        chk("rst_rdata", sresp.rdata, 0);
        chk("rst_intr", {31'd0, intr}, 0);
        chk("rst_eaddr", eaddr, 0);
        chk("rst_ecnt", {16'd0, ecnt}, 0);
        nxt;
        rst_ni = 1'b1;

        // normal read, rvalid three cycles after gnt
        nxt; drv(1, 32'h2000_0010, 0, 1, 0, 0);
        chk("t1_preq", {31'd0, preq.req}, 1);
        chk("t1_paddr", preq.addr, 32'h2000_0010);
        chk("t1_gnt", {31'd0, sresp.gnt}, 1);
        nxt; drv(1, 32'h2000_0020, 0, 1, 0, 0);
        chk("t1_block_req", {31'd0, preq.req}, 0);
        chk("t1_block_gnt", {31'd0, sresp.gnt}, 0);
        nxt; drv(0, 0, 0, 0, 0, 0);
        chk("t1_wait_rvalid", {31'd0, sresp.rvalid}, 0);
        nxt; drv(0, 0, 0, 0, 1, 32'h1234);
        chk("t1_rvalid", {31'd0, sresp.rvalid}, 1);
        chk("t1_rdata", sresp.rdata, 32'h1234);
        chk("t1_intr", {31'd0, intr}, 0);
        nxt; drv(0, 0, 0, 0, 0, 0);
        chk("t1_idle_rvalid", {31'd0, sresp.rvalid}, 0);
        chk("t1_idle_rdata", sresp.rdata, 0);

        // write never granted
        nxt; drv(1, 32'h2000_3000, 1, 0, 0, 0);
        chk("t2_preq", {31'd0, preq.req}, 1);
        chk("t2_pwe", {31'd0, preq.we}, 1);
        chk("t2_pwdata", preq.wdata, 32'h7A5A_6A5A);
        chk("t2_gnt0", {31'd0, sresp.gnt}, 0);
        for (int i = 0; i < 7; i++) begin
            nxt; drv(1, 32'h2000_3000, 1, 0, 0, 0);
            chk("t2_wait_gnt", {31'd0, sresp.gnt}, 0);
        end
        nxt; drv(1, 32'h2000_3000, 1, 0, 0, 0);
        chk("t2_to_gnt", {31'd0, sresp.gnt}, 1);
        chk("t2_to_preq", {31'd0, preq.req}, 0);
        nxt; drv(0, 0, 0, 0, 0, 0);
        chk("t2_err_rvalid", {31'd0, sresp.rvalid}, 1);
        chk("t2_err_rdata", sresp.rdata, 32'hBADC_AB1E);
        chk("t2_err_intr", {31'd0, intr}, 1);
        chk("t2_err_gnt", {31'd0, sresp.gnt}, 0);
        // back in IDLE: issue the next read straight away
        nxt; drv(1, 32'h2000_0100, 0, 1, 0, 0);
        chk("t2_idle_gnt", {31'd0, sresp.gnt}, 1);
        chk("t2_idle_intr", {31'd0, intr}, 0);
        chk("t2_eaddr", eaddr, 32'h2000_3000);
        chk("t2_ecnt", {16'd0, ecnt}, 32'(EN));

        // granted read, rvalid withheld, late rvalid swallowed
        for (int i = 0; i < 8; i++) begin
            nxt; drv(0, 0, 0, 0, 0, 0);
            chk("t3_wait_rvalid", {31'd0, sresp.rvalid}, 0);
        end
        nxt; drv(0, 0, 0, 0, 0, 0);
        chk("t3_err_rvalid", {31'd0, sresp.rvalid}, 1);
        chk("t3_err_rdata", sresp.rdata, 32'hBADC_AB1E);
        chk("t3_err_intr", {31'd0, intr}, 1);
        nxt; drv(1, 32'h2000_0300, 0, 1, 0, 0);
        chk("t3_flush_preq", {31'd0, preq.req}, 0);
        chk("t3_flush_gnt", {31'd0, sresp.gnt}, 0);
        chk("t3_flush_intr", {31'd0, intr}, 0);
        nxt; drv(0, 0, 0, 0, 1, 32'h5555);
        chk("t3_late_rvalid", {31'd0, sresp.rvalid}, 0);
        chk("t3_late_rdata", sresp.rdata, 0);
        nxt; drv(1, 32'h2000_0200, 0, 1, 0, 0);
        chk("t3_next_preq", {31'd0, preq.req}, 1);
        chk("t3_next_gnt", {31'd0, sresp.gnt}, 1);
        chk("t3_eaddr", eaddr, 32'h2000_0100);
        nxt; drv(0, 0, 0, 0, 1, 32'hCAFE);
        chk("t3_next_rvalid", {31'd0, sresp.rvalid}, 1);
        chk("t3_next_rdata", sresp.rdata, 32'hCAFE);

        // rvalid on the last counter value wins over the timeout
        nxt; drv(1, 32'h2000_0400, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            nxt; drv(0, 0, 0, 0, 0, 0);
        end
        nxt; drv(0, 0, 0, 0, 1, 32'h7777);
        chk("t4_rvalid", {31'd0, sresp.rvalid}, 1);
        chk("t4_rdata", sresp.rdata, 32'h7777);
        chk("t4_intr", {31'd0, intr}, 0);
        nxt; drv(0, 0, 0, 0, 0, 0);
        chk("t4_after_rvalid", {31'd0, sresp.rvalid}, 0);
        chk("t4_after_intr", {31'd0, intr}, 0);
        chk("t4_ecnt", {16'd0, ecnt}, 32'(EN * 2));
        chk("t4_eaddr", eaddr, 32'h2000_0100);

        // gnt on the last counter value wins over the timeout
        nxt; drv(1, 32'h2000_0500, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            nxt; drv(1, 32'h2000_0500, 0, 0, 0, 0);
        end
        nxt; drv(1, 32'h2000_0500, 0, 1, 0, 0);
        chk("t5_gnt", {31'd0, sresp.gnt}, 1);
        chk("t5_preq", {31'd0, preq.req}, 1);
        nxt; drv(0, 0, 0, 0, 1, 32'hAAAA);
        chk("t5_rdata", sresp.rdata, 32'hAAAA);
        chk("t5_intr", {31'd0, intr}, 0);

        // third timeout for the error counter
        nxt; drv(1, 32'h2000_0600, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            nxt; drv(1, 32'h2000_0600, 1, 0, 0, 0);
        end
        nxt; drv(0, 0, 0, 0, 0, 0);
        chk("t5_err_intr", {31'd0, intr}, 1);
        nxt; drv(0, 0, 0, 0, 0, 0);
        chk("t5_ecnt", {16'd0, ecnt}, 32'(EN * 3));
        chk("t5_eaddr", eaddr, 32'h2000_0600);

        // reset during WAIT_RVALID
        nxt; drv(1, 32'h2000_0700, 0, 1, 0, 0);
        nxt; drv(0, 0, 0, 0, 0, 0);
        nxt; drv(0, 0, 0, 0, 0, 0);
        nxt; rst_ni = 1'b0; drv(0, 0, 0, 0, 0, 0);
        chk("t6_gnt", {31'd0, sresp.gnt}, 0);
        chk("t6_rvalid", {31'd0, sresp.rvalid}, 0);
        chk("t6_rdata", sresp.rdata, 0);
        chk("t6_intr", {31'd0, intr}, 0);
        chk("t6_eaddr", eaddr, 0);
        chk("t6_ecnt", {16'd0, ecnt}, 0);
        nxt; rst_ni = 1'b1; drv(1, 32'h2000_0800, 0, 1, 0, 0);
        chk("t6_preq", {31'd0, preq.req}, 1);
        chk("t6_paddr", preq.addr, 32'h2000_0800);
        chk("t6_fwd_gnt", {31'd0, sresp.gnt}, 1);
        nxt; drv(0, 0, 0, 0, 1, 32'h8888);
        chk("t6_rvalid_data", sresp.rdata, 32'h8888);
        chk("t6_rvalid_after", {31'd0, sresp.rvalid}, 1);
        nxt; drv(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
